// File: rtl/add_sub_pipe.sv
// Pipelined adder/subtractor: the carry chain is cut into CHUNK-bit slices, one per stage.
// Upper operand chunks are skewed in and finished low chunks de-skewed so each op exits whole.

module add_sub_lane #(
   parameter int CHUNK = 8,
   parameter int IDX   = 0,
   parameter int NSTG  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             adv,
   input  logic [CHUNK-1:0] a_in,
   input  logic [CHUNK-1:0] b_in,
   input  logic [CHUNK-1:0] sum,
   output logic [CHUNK-1:0] a_stg,
   output logic [CHUNK-1:0] b_stg,
   output logic [CHUNK-1:0] res_nxt
);
   // chunk IDX is added in stage IDX, then waits DSK stages for the upper chunks
   localparam int DSK = NSTG - 1 - IDX;

   generate
      if (IDX == 0) begin : g_no_skew
         assign a_stg = a_in;
         assign b_stg = b_in;
      end else begin : g_skew
         logic [CHUNK-1:0] a_sr [1:IDX];
         logic [CHUNK-1:0] b_sr [1:IDX];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 1; i <= IDX; i++) begin
                  a_sr[i] <= '0;
                  b_sr[i] <= '0;
               end
            end else if (adv) begin
               a_sr[1] <= a_in;
               b_sr[1] <= b_in;
               for (int i = 2; i <= IDX; i++) begin
                  a_sr[i] <= a_sr[i-1];
                  b_sr[i] <= b_sr[i-1];
               end
            end
         end

         assign a_stg = a_sr[IDX];
         assign b_stg = b_sr[IDX];
      end

      if (DSK == 0) begin : g_no_dskw
         assign res_nxt = sum;
      end else begin : g_dskw
         logic [CHUNK-1:0] r_sr [1:DSK];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 1; i <= DSK; i++) r_sr[i] <= '0;
            end else if (adv) begin
               r_sr[1] <= sum;
               for (int i = 2; i <= DSK; i++) r_sr[i] <= r_sr[i-1];
            end
         end

         assign res_nxt = r_sr[DSK];
      end
   endgenerate
endmodule

module add_sub_pipe #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ad_o_sb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] rslt,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);
   localparam int NSTG = WIDTH / CHUNK;

   logic                       adv;
   logic [NSTG-1:0]            vld_pipe;
   logic [WIDTH-1:0]           b_x;
   logic [NSTG-1:0][CHUNK-1:0] a_stg, b_stg, sum, res_nxt;
   logic [NSTG-1:0]            cin, co, cy_q;
   logic                       ovf_nxt;

   generate
      if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_bad_cfg
         $error("add_sub_pipe: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   // the whole pipe moves or holds as one; bubbles only stop during a stall
   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_pipe[NSTG-1];

   // subtract is a + ~b + 1: invert here, the +1 is the stage-0 carry-in
   assign b_x = b ^ {WIDTH{ad_o_sb}};

   generate
      for (genvar k = 0; k < NSTG; k++) begin : g_stage
         if (k == 0) begin : g_c0
            assign cin[k] = ad_o_sb;
         end else begin : g_cn
            assign cin[k] = cy_q[k-1];
         end

         assign {co[k], sum[k]} = {1'b0, a_stg[k]} + {1'b0, b_stg[k]} + {{CHUNK{1'b0}}, cin[k]};

         add_sub_lane #(
            .CHUNK (CHUNK),
            .IDX   (k),
            .NSTG  (NSTG)
         ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .adv     (adv),
            .a_in    (a[k*CHUNK +: CHUNK]),
            .b_in    (b_x[k*CHUNK +: CHUNK]),
            .sum     (sum[k]),
            .a_stg   (a_stg[k]),
            .b_stg   (b_stg[k]),
            .res_nxt (res_nxt[k])
         );
      end
   endgenerate

   // carry into the MSB recovered from the top chunk's sign bits
   assign ovf_nxt = a_stg[NSTG-1][CHUNK-1] ^ b_stg[NSTG-1][CHUNK-1]
                  ^ sum[NSTG-1][CHUNK-1] ^ co[NSTG-1];

   // cy_q[NSTG-1] is the registered carry out of the MSB, i.e. cout
   assign cout = cy_q[NSTG-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         cy_q     <= '0;
         rslt     <= '0;
         ovf      <= 1'b0;
         zero     <= 1'b0;
      end else if (adv) begin
         vld_pipe[0] <= in_valid;
         for (int i = 1; i < NSTG; i++) vld_pipe[i] <= vld_pipe[i-1];
         cy_q <= co;
         rslt <= res_nxt;
         ovf  <= ovf_nxt;
         zero <= (res_nxt == '0);
      end
   end
endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: directed vectors, random streams with backpressure, reset mid-flight.
// Outputs are scored against an arithmetic reference model through an in-order queue.

module tb_add_sub_pipe;
   localparam int WIDTH = 32;
   localparam int CHUNK = 8;
   localparam int NSTG  = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             ad_o_sb = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] rslt;
   logic             cout, ovf, zero;

   always #5 clk = ~clk;

   add_sub_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .ad_o_sb   (ad_o_sb),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .rslt      (rslt),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   typedef struct {
      logic [31:0] r;
      logic        c, v, z;
      int          cyc;
      int          stl;
   } exp_t;

   typedef struct {
      logic [31:0] a, b;
      logic        sub;
      logic [31:0] r;
      logic        c, v, z;
   } vec_t;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   stall_cnt = 0;
   logic stall_prev = 1'b0;
   logic [35:0] held = '0;
   exp_t exp_q [$];
   exp_t mon_e;
   vec_t vt [9];

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, req);
      end
   endfunction

   // plain integer arithmetic, independent of how the carry chain is cut
   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
      exp_t   e;
      longint ux = longint'(x);
      longint uy = longint'(y);
      longint sx = longint'($signed(x));
      longint sy = longint'($signed(y));
      longint us = s ? ux - uy : ux + uy;
      longint ss = s ? sx - sy : sx + sy;
      e.r   = us[31:0];
      e.c   = s ? (ux >= uy) : ((us >> 32) != 0);
      e.v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      e.z   = (e.r == 32'd0);
      e.cyc = 0;
      e.stl = 0;
      return e;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard: push at acceptance, pop at output handshake, watch stalls
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         stall_prev = 1'b0;
      end else begin
         chk("in_ready_rule", in_ready, (!out_valid || out_ready));
         if (stall_prev) chk("stall_hold", {out_valid, cout, ovf, zero, rslt}, held);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", out_valid, 0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("sb_rslt", rslt, mon_e.r);
               chk("sb_cout", cout, mon_e.c);
               chk("sb_ovf", ovf, mon_e.v);
               chk("sb_zero", zero, mon_e.z);
               chk("sb_latency", cyc - mon_e.cyc, NSTG + stall_cnt - mon_e.stl);
            end
         end
         if (out_valid && !out_ready) begin
            held = {out_valid, cout, ovf, zero, rslt};
            stall_cnt++;
            stall_prev = 1'b1;
         end else begin
            stall_prev = 1'b0;
         end
         if (in_valid && in_ready) begin
            mon_e = model(a, b, ad_o_sb);
            mon_e.cyc = cyc;
            mon_e.stl = stall_cnt;
            exp_q.push_back(mon_e);
         end
      end
   end

   task automatic run_vec(input vec_t v, input string nm);
      @(posedge clk); #1;
      a = v.a; b = v.b; ad_o_sb = v.sub; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; ad_o_sb = ~v.sub;
      repeat (NSTG - 1) begin
         @(negedge clk);
         chk({nm, "_early"}, out_valid, 0);
         @(posedge clk);
      end
      @(negedge clk);
      chk({nm, "_vld"}, out_valid, 1);
      chk({nm, "_rslt"}, rslt, v.r);
      chk({nm, "_cout"}, cout, v.c);
      chk({nm, "_ovf"}, ovf, v.v);
      chk({nm, "_zero"}, zero, v.z);
   endtask

   task automatic stream(input int n, input int st_from, input int st_len);
      int   j = 0;
      logic acc;
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         a = $urandom; b = $urandom; ad_o_sb = 1'($urandom_range(0, 1)); in_valid = 1'b1;
         if (i % 7 == 3) b = a;
         do begin
            out_ready = !(j >= st_from && j < st_from + st_len);
            j++;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
         end while (!acc);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic drain(input string nm);
      int k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_drain"}, exp_q.size(), 0);
   endtask

   initial begin
      vt[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vt[1] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
      vt[2] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      vt[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
      vt[4] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0, 1'b0};
      vt[5] = '{32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vt[6] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
      vt[7] = '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
      vt[8] = '{32'h00000000, 32'h80000000, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0};

      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_rslt", rslt, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_zero", zero, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      for (int i = 0; i < 9; i++) run_vec(vt[i], $sformatf("vec%0d", i));

      stream(16, -1, 0);
      drain("stream");
      stream(12, 6, 5);
      drain("backpress");

      // reset with three ops in flight
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         a = $urandom; b = $urandom; ad_o_sb = 1'($urandom_range(0, 1)); in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_rslt", rslt, 0);
      chk("mid_rst_cout", cout, 0);
      chk("mid_rst_ovf", ovf, 0);
      chk("mid_rst_zero", zero, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("no_stale", out_valid, 0);
      end
      run_vec(vt[4], "post_rst");
      drain("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/add_sub_pipe.md
ADD_SUB_PIPE -- requirements
Module: add_sub_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter CHUNK, default 8: bits added per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK; NSTG = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operands and mode present this cycle.
REQ-006 in_ready  output  1  block accepts an operation this cycle.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 ad_o_sb  input  1  mode: 0 = a+b, 1 = a-b.
REQ-010 out_valid  output  1  result fields valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 rslt  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-013 cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
REQ-014 ovf  output  1  two's-complement signed overflow.
REQ-015 zero  output  1  rslt == 0.

Function
REQ-016 An operation SHALL be accepted on a cycle where in_valid && in_ready.
REQ-017 Subtract SHALL be computed as a + ~b + 1; add as a + b + 0; the carry-in SHALL equal ad_o_sb.
REQ-018 Stage k (0..NSTG-1) SHALL add chunk k of a and of the (conditionally inverted) b with the carry registered from stage k-1; stage 0 uses ad_o_sb as its carry-in.
REQ-019 Upper operand chunks SHALL be skewed through registers, and completed lower result chunks de-skewed, so that all chunks of one operation exit together.
REQ-020 Latency SHALL be exactly NSTG cycles from acceptance to out_valid with no stall; NSTG=1 gives 1 cycle.
REQ-021 Throughput SHALL be one operation per cycle when out_ready stays high.
REQ-022 Each stage SHALL carry a valid bit; out_valid SHALL be the valid bit of the last stage.
REQ-023 Stall: when out_valid && !out_ready, the whole pipeline SHALL hold; rslt, cout, ovf and zero SHALL stay stable, and no valid operation SHALL be lost or duplicated.
REQ-024 in_ready SHALL equal !out_valid || out_ready.
REQ-025 Bubbles (invalid stages) SHALL advance while the pipeline is not stalled; they are not compressed during a stall.
REQ-026 Simultaneous output handshake and input acceptance in one cycle SHALL both take effect.
REQ-027 ovf SHALL be the carry into the MSB XOR the carry out of the MSB.
REQ-028 zero SHALL be computed on the full assembled rslt, registered with it.
REQ-029 Result fields SHALL be don't-care when out_valid=0, but SHALL NOT contain X after reset.
REQ-030 Operands and mode SHALL be captured at acceptance; input changes afterward do not affect operations in flight.

Reset
REQ-031 When rst_n=0: all stage valid bits SHALL clear immediately (asynchronously), and out_valid=0, rslt=0, cout=0, ovf=0, zero=0.
REQ-032 in_ready SHALL be 1 while in reset and after reset.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight operations; none SHALL appear after release.
REQ-034 The first accepted operation after rst_n rises SHALL produce out_valid exactly NSTG cycles later.

Verification (WIDTH=32, CHUNK=8, NSTG=4)
REQ-035 Add a=0xFFFFFFFF, b=0x00000001, ad_o_sb=0 -> 4 cycles later rslt=0, cout=1, ovf=0, zero=1.
REQ-036 Subtract a=0x80000000, b=0x00000001 -> rslt=0x7FFFFFFF, cout=1, ovf=1, zero=0; subtract a=5, b=7 -> rslt=0xFFFFFFFE, cout=0, ovf=0.
REQ-037 Add a=0x7FFFFFFF, b=1 -> rslt=0x80000000, ovf=1, cout=0; add a=0x00FF00FF, b=0x00010001 -> rslt=0x01000100, which exercises the inter-chunk carries.
REQ-038 Streaming: 16 back-to-back random ops with out_ready=1 -> results in order, one per cycle, first at cycle 4; all match the reference model.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 while out_valid=1, output stable, no loss or duplication after release.
REQ-040 Assert rst_n=0 with 3 ops in flight -> out_valid=0 immediately, all outputs 0; after release, no stale results and a new op returns at cycle 4.
